// File: rtl/stepper_pkg.sv
// Shared types for the stepper motion sequencer: FSM states and coil-driver command codes.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL
  } state_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_FWD  = 2'b01;
  localparam logic [1:0] CMD_REV  = 2'b10;

endpackage

// File: rtl/stepper_step_timer.sv
// Step-period down-counter: expire strobes in the cycle the count runs out, so a load of N
// yields an expire strobe N cycles later when enabled continuously.
module stepper_step_timer #(
  parameter int PER_W = 12
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             load,
  input  logic [PER_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [PER_W-1:0] count;

  assign expire = en & (count <= PER_W'(1));

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!system1000_rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/stepper_motion_sequencer.sv
// Trapezoidal-ramp stepper sequencer: accepts signed relative moves, issues step/dir commands.
// Optional ramped stop input enabled by defining STEPPER_SOFT_STOP_EN.
module stepper_motion_sequencer
  import stepper_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int PER_W        = 12,
  parameter int START_PERIOD = 200,
  parameter int MIN_PERIOD   = 20,
  parameter int ACCEL_STEP   = 4
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    move_valid,
  output logic                    move_ready,
  input  logic signed [POS_W-1:0] move_steps,
  input  logic                    abort,
`ifdef STEPPER_SOFT_STOP_EN
  input  logic                    soft_stop,
`endif
  output logic [1:0]              motor_cmd,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0] STEP_P  = PER_W'(ACCEL_STEP);

  state_t                  state, state_nxt;
  logic                    dir, dir_nxt;
  logic [POS_W-1:0]        remaining, remaining_nxt, accel_cnt, accel_cnt_nxt;
  logic [POS_W-1:0]        rem_src, rem_dec;
  logic [PER_W-1:0]        period, period_nxt, tmr_load_val;
  logic [PER_W:0]          dec_sum;
  logic [1:0]              cmd_nxt;
  logic                    done_nxt, tmr_load, step, soft_req, accept;
  logic signed [POS_W-1:0] position_nxt;

  assign move_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = move_valid & move_ready & ~abort;
  assign dec_sum    = {1'b0, period} + {1'b0, STEP_P};

`ifdef STEPPER_SOFT_STOP_EN
  assign soft_req = soft_stop & ((state == ACCEL) | (state == CRUISE));
`else
  assign soft_req = 1'b0;
`endif

  stepper_step_timer #(.PER_W(PER_W)) u_step_timer (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .load            (tmr_load),
    .load_val        (tmr_load_val),
    .en              (busy),
    .expire          (step)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    dir_nxt       = dir;
    remaining_nxt = remaining;
    accel_cnt_nxt = accel_cnt;
    period_nxt    = period;
    position_nxt  = position;
    cmd_nxt       = CMD_HOLD;
    done_nxt      = 1'b0;
    tmr_load      = 1'b0;
    tmr_load_val  = period;
    rem_src       = remaining;
    rem_dec       = remaining;

    if (state == IDLE) begin
      if (accept) begin
        if (move_steps == '0) begin
          done_nxt = 1'b1;
        end else begin
          state_nxt     = ACCEL;
          dir_nxt       = move_steps[POS_W-1];
          remaining_nxt = move_steps[POS_W-1] ? -move_steps : move_steps;
          accel_cnt_nxt = '0;
          period_nxt    = START_P;
          tmr_load      = 1'b1;
          tmr_load_val  = START_P;
        end
      end
    end else if (abort) begin
      state_nxt = IDLE;
    end else begin
      // A ramped stop leaves exactly enough steps to mirror the ramp already climbed.
      if (soft_req) rem_src = accel_cnt + 1'b1;
      remaining_nxt = rem_src;
      if (step) begin
        rem_dec       = rem_src - 1'b1;
        remaining_nxt = rem_dec;
        cmd_nxt       = dir ? CMD_REV : CMD_FWD;
        position_nxt  = dir ? position - 1'b1 : position + 1'b1;
        if (rem_dec == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          if (rem_dec <= accel_cnt) begin
            state_nxt = DECEL;
          end else if ((state == ACCEL) && (period <= MIN_P)) begin
            state_nxt = CRUISE;
          end
          if (state_nxt == ACCEL) begin
            period_nxt    = ((period - MIN_P) >= STEP_P) ? period - STEP_P : MIN_P;
            accel_cnt_nxt = accel_cnt + 1'b1;
          end else if (state_nxt == DECEL) begin
            period_nxt = (dec_sum > {1'b0, START_P}) ? START_P : dec_sum[PER_W-1:0];
          end
          tmr_load     = 1'b1;
          tmr_load_val = period_nxt;
        end
      end
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state     <= IDLE;
      dir       <= 1'b0;
      remaining <= '0;
      accel_cnt <= '0;
      period    <= START_P;
      motor_cmd <= CMD_HOLD;
      done      <= 1'b0;
      position  <= '0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      remaining <= remaining_nxt;
      accel_cnt <= accel_cnt_nxt;
      period    <= period_nxt;
      motor_cmd <= cmd_nxt;
      done      <= done_nxt;
      position  <= position_nxt;
    end
  end

endmodule

// File: tb/tb_stepper_motion_sequencer.sv
// Scoreboard bench for stepper_motion_sequencer: drivers queue expected step/done events,
// a negedge monitor pops and compares them. Soft-stop scenario runs when STEPPER_SOFT_STOP_EN is defined.
module tb_stepper_motion_sequencer;
  import stepper_pkg::*;

  typedef struct {
    logic [1:0]         cmd;
    logic               done;
    logic signed [15:0] pos;
    int                 at;   // cycles after the handshake cycle, -1 = untimed
  } exp_t;

  logic               system1000 = 1'b0;
  logic               system1000_rstn;
  logic               move_valid;
  logic               move_ready;
  logic signed [15:0] move_steps;
  logic               abort;
`ifdef STEPPER_SOFT_STOP_EN
  logic               soft_stop;
`endif
  logic [1:0]         motor_cmd;
  logic               busy;
  logic               done;
  logic signed [15:0] position;

  exp_t               exp_q[$];
  exp_t               mon_e;
  int                 n_tests = 0;
  int                 n_fail  = 0;
  int                 cyc     = 0;
  int                 acc_cyc = 0;
  logic               mon_en  = 1'b0;
  logic signed [15:0] model_pos;

  stepper_motion_sequencer dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .move_valid      (move_valid),
    .move_ready      (move_ready),
    .move_steps      (move_steps),
    .abort           (abort),
`ifdef STEPPER_SOFT_STOP_EN
    .soft_stop       (soft_stop),
`endif
    .motor_cmd       (motor_cmd),
    .busy            (busy),
    .done            (done),
    .position        (position)
  );

  always #5 system1000 = ~system1000;
  always @(posedge system1000) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void push_exp(input logic [1:0] c, input logic d,
                                   input logic signed [15:0] p, input int at);
    exp_t e;
    e.cmd = c; e.done = d; e.pos = p; e.at = at;
    exp_q.push_back(e);
  endfunction

  // Monitor: every step pulse or done pulse must match the head of the scoreboard.
  always @(negedge system1000) begin
    if (mon_en && (motor_cmd != CMD_HOLD || done)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: cmd=%b done=%b pos=%0d at +%0d, expected no output",
                 motor_cmd, done, position, cyc - acc_cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_cmd", 32'(motor_cmd), 32'(mon_e.cmd));
        check("mon_done", 32'(done), 32'(mon_e.done));
        check("mon_pos", 32'(position), 32'(mon_e.pos));
        if (mon_e.at >= 0) check("mon_time", 32'(cyc - acc_cyc), 32'(mon_e.at));
      end
    end
  end

  task automatic do_move(input logic signed [15:0] steps);
    @(negedge system1000);
    check("ready_before_accept", 32'(move_ready), 32'd1);
    move_steps = steps;
    move_valid = 1'b1;
    acc_cyc    = cyc;
    @(posedge system1000);
    #1;
    move_valid = 1'b0;
  endtask

  task automatic wait_offset(input int off);
    while (cyc - acc_cyc < off) @(negedge system1000);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge system1000);
      n++;
    end while (busy && n < limit);
    check({name, "_idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge system1000);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_pos"}, 32'(position), 32'(model_pos));
    check({name, "_ready"}, 32'(move_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    system1000_rstn = 1'b0;
    move_valid      = 1'b0;
    move_steps      = '0;
    abort           = 1'b0;
`ifdef STEPPER_SOFT_STOP_EN
    soft_stop       = 1'b0;
`endif
    model_pos       = '0;
    repeat (3) @(negedge system1000);
    system1000_rstn = 1'b1;
    @(negedge system1000);

    // T1 reset state
    check("t1_cmd", 32'(motor_cmd), 32'(CMD_HOLD));
    check("t1_pos", 32'(position), 32'd0);
    check("t1_ready", 32'(move_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    mon_en = 1'b1;

    // T2 +3: periods 200, 196, 200
    push_exp(CMD_FWD, 1'b0, 16'sd1, 201);
    push_exp(CMD_FWD, 1'b0, 16'sd2, 397);
    push_exp(CMD_FWD, 1'b1, 16'sd3, 597);
    do_move(16'sd3);
    model_pos = 16'sd3;
    wait_idle("t2", 1000);

    // T3 -1000: 45 ramp steps, cruise at 20, mirrored ramp down; last pulse at 201+4860+18180+5040
    for (int k = 1; k <= 1000; k++) begin
      push_exp(CMD_REV, (k == 1000), 16'(3 - k),
               (k == 1) ? 201 : (k == 46) ? 5061 : (k == 47) ? 5081 :
               (k == 1000) ? 28281 : -1);
    end
    do_move(-16'sd1000);
    model_pos = -16'sd997;
    wait_idle("t3", 30000);

    // T4 zero move: done only, one cycle after the handshake
    push_exp(CMD_HOLD, 1'b1, -16'sd997, 1);
    do_move(16'sd0);
    for (int i = 0; i < 3; i++) begin
      check("t4_busy", 32'(busy), 32'd0);
      @(negedge system1000);
    end
    wait_idle("t4", 10);

    // abort in IDLE beats a same-cycle accept
    @(negedge system1000);
    move_valid = 1'b1;
    move_steps = 16'sd7;
    abort      = 1'b1;
    @(posedge system1000);
    #1;
    move_valid = 1'b0;
    abort      = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    wait_idle("idle_abort", 10);

    // T5 +200, abort on the step cycle of pulse 51 (cruise), stray move_valid mid-move
    for (int k = 1; k <= 50; k++) begin
      push_exp(CMD_FWD, 1'b0, 16'(-997 + k), (k == 46) ? 5061 : (k == 50) ? 5141 : -1);
    end
    do_move(16'sd200);
    wait_offset(3000);
    move_valid = 1'b1;
    move_steps = -16'sd5;
    @(posedge system1000);
    #1;
    move_valid = 1'b0;
    wait_offset(5160);
    abort = 1'b1;
    @(posedge system1000);
    #1;
    abort = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cmd", 32'(motor_cmd), 32'(CMD_HOLD));
    check("t5_done", 32'(done), 32'd0);
    check("t5_pos_now", 32'(position), 32'(-16'sd947));
    model_pos = -16'sd947;
    repeat (30) @(negedge system1000);
    wait_idle("t5", 10);

`ifdef STEPPER_SOFT_STOP_EN
    // T6 +1000, soft stop right after pulse 60 -> 46 more steps, last at 5361+5040
    for (int k = 1; k <= 106; k++) begin
      push_exp(CMD_FWD, (k == 106), 16'(-947 + k),
               (k == 60) ? 5341 : (k == 61) ? 5361 : (k == 62) ? 5385 : (k == 106) ? 10401 : -1);
    end
    do_move(16'sd1000);
    wait_offset(5341);
    soft_stop = 1'b1;
    @(posedge system1000);
    #1;
    soft_stop = 1'b0;
    model_pos = -16'sd841;
    wait_idle("t6", 12000);
`endif

    // T7 async reset mid-move clears everything at once
    do_move(16'sd5);
    repeat (50) @(negedge system1000);
    mon_en = 1'b0;
    #2;
    system1000_rstn = 1'b0;
    #1;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_ready", 32'(move_ready), 32'd1);
    check("t7_pos", 32'(position), 32'd0);
    check("t7_cmd", 32'(motor_cmd), 32'(CMD_HOLD));
    @(negedge system1000);
    system1000_rstn = 1'b1;
    model_pos = '0;
    mon_en = 1'b1;
    repeat (300) @(negedge system1000);
    check("t7_still_idle", 32'(busy), 32'd0);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
